data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Word-addressed data-memory responder at the memory end of the processor's load/store interface.
- Accepts one request at a time over a valid/ready handshake and waits a programmable number of cycles.
- Then returns read data, or a write acknowledge, over a valid/ready response handshake.
- Flags out-of-range addresses; storage is internal.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 12, request address width; word addresses.
- DEPTH, 1024, number of implemented words; addresses >= DEPTH are out of range.
- WAIT_STATES, 2, extra cycles between request acceptance and response; 0..15 legal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  request address was out of range.
- busy  out  1  transaction in flight, i.e. state != IDLE.

Behaviour:
- Reset (rst low, async):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; busy = 0; wait counter = 0.
  - Memory array contents are not cleared.
  - Reset during WAIT or RESP discards the transaction; no response ever appears, and a pending write that has not yet committed is lost.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch write, addr, wdata and err = (addr >= DEPTH).
  - Next state is WAIT with counter = WAIT_STATES, or RESP directly if WAIT_STATES == 0.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - When the counter reaches 1, move to RESP on the next edge.
  - Total acceptance-edge to rsp_valid-high latency = WAIT_STATES + 1 cycles.
- Commit on entry to RESP (same edge rsp_valid rises):
  - Store, in range: mem[addr] <= wdata.
  - Load, in range: rsp_rdata <= mem[addr].
  - Out of range: no memory access; rsp_rdata = 0; rsp_err = 1.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready is sampled high.
  - On rsp_valid & rsp_ready: rsp_valid, rsp_err and rsp_rdata clear to 0, state returns to IDLE, and req_ready = 1 the following cycle.
  - No request is accepted in the same cycle as the response handshake.
- Throughput: at most one transaction per WAIT_STATES + 3 cycles when rsp_ready is held high.
- req_valid may drop before acceptance without effect. Inputs are ignored outside IDLE.
- Load from a location never written returns X in simulation; the bench must write before reading.
- Address width: req_addr is compared unsigned against DEPTH.
  - When DEPTH == 2**ADDR_W, rsp_err is never set.
  - Only the low clog2(DEPTH) address bits index the array.

Decomposition:
- Shared package mem_if_pkg holds the state enum (IDLE, WAIT, RESP), the DATA_W/ADDR_W defaults and a request struct {write, addr, wdata}, so the processor datapath and the responder agree on field widths.
- One sub-module is natural: mem_array, a single-port synchronous RAM (DEPTH x DATA_W, write-enable, registered read).
- The FSM, wait counter and handshake logic stay in data_mem_responder.

Test Plan:
- Reset release, no traffic -> req_ready = 1, rsp_valid = 0, busy = 0 for 10 cycles.
- Store addr 0x005 data 0xBEEF, WAIT_STATES = 2, rsp_ready = 1 -> rsp_valid high exactly 3 cycles after acceptance, rsp_err = 0, rsp_rdata = 0; then a load of 0x005 returns 0xBEEF with the same latency.
- Load addr 0x400 (DEPTH = 1024) -> rsp_err = 1, rsp_rdata = 0; a following load of addr 0x000 is unaffected by any write.
- rsp_ready held low 5 cycles during RESP -> rsp_valid and rsp_rdata stable; req_ready = 0 throughout; a req_valid pulse during this window is not accepted.
- Assert rst low mid-WAIT after a store to 0x010 -> outputs return to reset values immediately; no rsp_valid afterwards; the load then issued to 0x010 returns the prior contents, not the dropped data.
- Back-to-back stores to 0x001..0x008 then loads with WAIT_STATES = 0 -> each response 1 cycle after acceptance; data matches; one transaction per 3 cycles.

Source files
------------

// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the processor load/store interface and the data-memory
// responder: default field widths, the responder FSM state encoding and the
// request record. Both ends of the interface import this package so they agree
// on field widths.
// -----------------------------------------------------------------------------
package mem_if_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request as issued by the processor datapath (default widths).
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, DEPTH x DATA_W, with a registered read port.
// Contents are never reset.
//   clk    in  clock
//   en     in  access enable for this cycle
//   we     in  1 = write wdata to idx, 0 = read idx into rdata register
//   idx    in  word index
//   wdata  in  write data
//   rdata  out registered read data (holds until the next enabled read)
// -----------------------------------------------------------------------------
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read; the read register only moves on a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Word-addressed data-memory responder. Accepts one request at a time, waits
// WAIT_STATES cycles, commits the access and presents a response that is held
// until the requester takes it.
//   clk        in  clock
//   rst        in  asynchronous active-low reset
//   req_valid  in  request present
//   req_ready  out responder can accept a request
//   req_write  in  1 = store, 0 = load
//   req_addr   in  word address
//   req_wdata  in  store data
//   rsp_valid  out response present
//   rsp_ready  in  requester accepts the response
//   rsp_rdata  out load data (0 for stores and errors)
//   rsp_err    out request address was out of range
//   busy       out transaction in flight
// -----------------------------------------------------------------------------
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic       ZERO_WAIT = (WAIT_STATES == 0);

  // Unsigned range check; never fires when DEPTH covers the whole address space.
  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return (32'(a) >= 32'(DEPTH));
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q, rsp_valid_q, rsp_err_q, rd_sel_q, busy_q;

  logic              accept_s, enter_resp_s, rsp_done_s;
  logic              cur_write_s, cur_err_s;
  logic [IDX_W-1:0]  cur_idx_s;
  logic [DATA_W-1:0] cur_wdata_s, ram_rdata_s;

  // With zero wait states RESP is entered on the acceptance edge, so the
  // commit must use the live request fields instead of the latched ones.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write_s = req_write;
      cur_err_s   = addr_oor(req_addr);
      cur_idx_s   = req_addr[IDX_W-1:0];
      cur_wdata_s = req_wdata;
    end else begin
      cur_write_s = write_q;
      cur_err_s   = err_q;
      cur_idx_s   = idx_q;
      cur_wdata_s = wdata_q;
    end
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    rsp_done_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          accept_s = 1'b1;
          if (ZERO_WAIT) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d      = RESP;
          cnt_d        = 4'd0;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d    = IDLE;
          rsp_done_s = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM, request latch and registered response/handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      // Ready only after a full IDLE cycle: this leaves one bubble after each
      // response, so a new request is never taken next to the handshake.
      req_ready_q <= (state_q == IDLE) && (state_d == IDLE);
      if (accept_s) begin
        write_q <= req_write;
        err_q   <= addr_oor(req_addr);
        idx_q   <= req_addr[IDX_W-1:0];
        wdata_q <= req_wdata;
      end
      if (enter_resp_s) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err_s;
        rd_sel_q    <= !cur_write_s && !cur_err_s;
      end else if (rsp_done_s) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rd_sel_q    <= 1'b0;
      end
    end
  end

  // Out-of-range requests never touch the array, so they cannot alias.
  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .en    (enter_resp_s && !cur_err_s),
    .we    (cur_write_s),
    .idx   (cur_idx_s),
    .wdata (cur_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  // The RAM read register is not reset; the select flag forces 0 when idle.
  assign rsp_rdata = rd_sel_q ? ram_rdata_s : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder. Instance 0 uses WAIT_STATES = 2,
// instance 1 uses WAIT_STATES = 0; both share clock and reset.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  logic [1:0]    req_valid, req_write, rsp_ready;
  logic [1:0]    req_ready, rsp_valid, rsp_err, busy;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic [DW-1:0] rsp_rdata [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure acceptance spacing.
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on instance d. hold = cycles to keep rsp_ready low once the
  // response is up; during a hold a stray store pulse is driven to the same
  // address and must be ignored. Returns at the cycle after the handshake.
  task automatic do_txn(input int d, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                        input logic exp_err, input int exp_lat, input int hold,
                        input string tag, output int acc_cyc);
    int n;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    rsp_ready[d] = (hold == 0);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
    step();
    acc_cyc = cyc;
    req_valid[d] = 1'b0;
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq({tag, ".latency"}, 32'(n), 32'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      check_eq({tag, ".hold_valid"}, 32'(rsp_valid[d]), 32'd1);
      check_eq({tag, ".hold_rdata"}, 32'(rsp_rdata[d]), 32'(exp_rd));
      check_eq({tag, ".hold_req_ready"}, 32'(req_ready[d]), 32'd0);
      if (k == 1) begin
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_wdata[d] = 16'hDEAD;
      end else begin
        req_valid[d] = 1'b0;
      end
      step();
    end
    rsp_ready[d] = 1'b1;
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
    check_eq({tag, ".rdata"}, 32'(rsp_rdata[d]), 32'(exp_rd));
    check_eq({tag, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
    check_eq({tag, ".busy"}, 32'(busy[d]), 32'd1);
    step();
    check_eq({tag, ".post_valid"}, 32'(rsp_valid[d]), 32'd0);
    check_eq({tag, ".post_rdata"}, 32'(rsp_rdata[d]), 32'd0);
    check_eq({tag, ".post_err"}, 32'(rsp_err[d]), 32'd0);
    check_eq({tag, ".post_busy"}, 32'(busy[d]), 32'd0);
    check_eq({tag, ".bubble"}, 32'(req_ready[d]), 32'd0);
  endtask

  logic [DW-1:0] vec [8] = '{16'hA001, 16'h5A02, 16'h0F03, 16'hF004,
                             16'h3C05, 16'hC306, 16'h7E07, 16'h8108};

  initial begin
    int   t;
    int   prev;
    logic seen;
    req_valid = 2'b00;
    req_write = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    step();
    step();
    rst = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 2; d++) begin
        check_eq("reset.req_ready", 32'(req_ready[d]), 32'd1);
        check_eq("reset.rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check_eq("reset.busy", 32'(busy[d]), 32'd0);
      end
      step();
    end

    // Store then load, WAIT_STATES = 2.
    do_txn(0, 1'b1, 12'h005, 16'hBEEF, 16'h0000, 1'b0, 3, 0, "st005", t);
    do_txn(0, 1'b0, 12'h005, 16'h0000, 16'hBEEF, 1'b0, 3, 0, "ld005", t);

    // Out-of-range accesses must not alias onto word 0.
    do_txn(0, 1'b1, 12'h000, 16'h1234, 16'h0000, 1'b0, 3, 0, "st000", t);
    do_txn(0, 1'b0, 12'h400, 16'h0000, 16'h0000, 1'b1, 3, 0, "ld400", t);
    do_txn(0, 1'b1, 12'h400, 16'h5555, 16'h0000, 1'b1, 3, 0, "st400", t);
    do_txn(0, 1'b1, 12'hFFF, 16'h6666, 16'h0000, 1'b1, 3, 0, "stFFF", t);
    do_txn(0, 1'b0, 12'h000, 16'h0000, 16'h1234, 1'b0, 3, 0, "ld000", t);

    // Response back-pressure with a stray request pulse.
    do_txn(0, 1'b1, 12'h020, 16'hA5A5, 16'h0000, 1'b0, 3, 0, "st020", t);
    do_txn(0, 1'b0, 12'h020, 16'h0000, 16'hA5A5, 1'b0, 3, 5, "ld020_hold", t);
    do_txn(0, 1'b0, 12'h020, 16'h0000, 16'hA5A5, 1'b0, 3, 0, "ld020_again", t);

    // Reset in the middle of WAIT drops a pending store.
    do_txn(0, 1'b1, 12'h010, 16'h1111, 16'h0000, 1'b0, 3, 0, "st010", t);
    step();
    check_eq("rstwait.ready_before", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 12'h010;
    req_wdata[0] = 16'h2222;
    step();
    req_valid[0] = 1'b0;
    check_eq("rstwait.busy_in_wait", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rstwait.req_ready", 32'(req_ready[0]), 32'd1);
    check_eq("rstwait.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check_eq("rstwait.busy", 32'(busy[0]), 32'd0);
    check_eq("rstwait.rdata", 32'(rsp_rdata[0]), 32'd0);
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid[0] === 1'b1) seen = 1'b1;
    end
    check_eq("rstwait.no_response", 32'(seen), 32'd0);
    do_txn(0, 1'b0, 12'h010, 16'h0000, 16'h1111, 1'b0, 3, 0, "ld010", t);

    // Zero wait states: back-to-back stores then loads, one per 3 cycles.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      do_txn(1, 1'b1, 12'(i + 1), vec[i], 16'h0000, 1'b0, 1, 0, "ws0_st", t);
      if (i > 0) check_eq("ws0_st.period", 32'(t - prev), 32'd3);
      prev = t;
    end
    for (int i = 0; i < 8; i++) begin
      do_txn(1, 1'b0, 12'(i + 1), 16'h0000, vec[i], 1'b0, 1, 0, "ws0_ld", t);
      if (i > 0) check_eq("ws0_ld.period", 32'(t - prev), 32'd3);
      prev = t;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
